frame_buffer_arbiter: RTL

FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

---
 rtl/frame_buffer_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/frame_buffer_arbiter.sv
// Double-buffered frame store arbiter: a single-port RAM is shared between scan-out
// reads (front bank, absolute priority) and renderer writes (back bank), with a vsync-gated swap.
module frame_buffer_arbiter #(
    parameter int X_SCREEN_PIXELS = 800,
    parameter int Y_SCREEN_PIXELS = 600,
    parameter int ADDR_WIDTH      = 20
) (
    input  logic                  CLOCK_400,
    input  logic                  reset,
    input  logic                  scan_req,
    input  logic [9:0]            scanX,
    input  logic [9:0]            scanY,
    output logic [7:0]            oR,
    output logic [7:0]            oG,
    output logic [7:0]            oB,
    output logic                  scan_valid,
    input  logic                  draw_req,
    input  logic [9:0]            buffX,
    input  logic [9:0]            buffY,
    input  logic [7:0]            iR,
    input  logic [7:0]            iG,
    input  logic [7:0]            iB,
    output logic                  draw_ack,
    input  logic                  newFrame,
    input  logic                  frame_end,
    output logic                  front_bank,
    output logic                  swap_pending,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [23:0]           mem_data,
    input  logic [23:0]           mem_q,
    output logic                  mem_wren
);

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} swap_state_t;

    localparam logic [10:0]           X_LIM     = 11'(X_SCREEN_PIXELS);
    localparam logic [10:0]           Y_LIM     = 11'(Y_SCREEN_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] X_W       = ADDR_WIDTH'(X_SCREEN_PIXELS);
    localparam logic [ADDR_WIDTH-1:0] BANK_SIZE = ADDR_WIDTH'(X_SCREEN_PIXELS * Y_SCREEN_PIXELS);

    function automatic logic [ADDR_WIDTH-1:0] pixel_addr(input logic bank,
                                                          input logic [9:0] x,
                                                          input logic [9:0] y);
        return (bank ? BANK_SIZE : '0) + ADDR_WIDTH'(y) * X_W + ADDR_WIDTH'(x);
    endfunction

    swap_state_t state_reg, state_next;
    logic        front_bank_reg, front_bank_next;
    logic        swap_now;

    logic                  draw_ack_reg;
    logic                  mem_wren_reg;
    logic [ADDR_WIDTH-1:0] mem_address_reg;
    logic [23:0]           mem_data_reg;
    logic [1:0]            rd_valid_reg;
    logic [1:0]            rd_blank_reg;
    logic                  scan_valid_reg;

    logic scan_in_range, draw_in_range;
    logic scan_grant, draw_grant, draw_write;

    // ---------------- swap FSM ----------------
    always_ff @(posedge CLOCK_400) begin
        if (reset) begin
            state_reg      <= IDLE;
            front_bank_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            front_bank_reg <= front_bank_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (newFrame)  state_next = PENDING;
            PENDING: if (frame_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        swap_pending    = (state_reg == PENDING);
        swap_now        = (state_reg == PENDING) && frame_end;
        front_bank_next = front_bank_reg ^ swap_now;
    end

    // ---------------- RAM arbitration ----------------
    always_comb begin
        scan_in_range = ({1'b0, scanX} < X_LIM) && ({1'b0, scanY} < Y_LIM);
        draw_in_range = ({1'b0, buffX} < X_LIM) && ({1'b0, buffY} < Y_LIM);
        // An off-screen scan needs no RAM, so its slot is free for the renderer.
        scan_grant    = scan_req && scan_in_range;
        draw_grant    = draw_req && !scan_grant && !draw_ack_reg;
        draw_write    = draw_grant && draw_in_range;
    end

    always_ff @(posedge CLOCK_400) begin
        if (reset) begin
            draw_ack_reg    <= 1'b0;
            mem_wren_reg    <= 1'b0;
            mem_address_reg <= '0;
            mem_data_reg    <= '0;
            rd_valid_reg    <= '0;
            rd_blank_reg    <= '0;
            scan_valid_reg  <= 1'b0;
        end else begin
            draw_ack_reg <= draw_grant;
            mem_wren_reg <= draw_write;
            if (scan_grant) begin
                mem_address_reg <= pixel_addr(front_bank_reg, scanX, scanY);
            end else if (draw_write) begin
                mem_address_reg <= pixel_addr(!front_bank_reg, buffX, buffY);
                mem_data_reg    <= {iR, iG, iB};
            end
            rd_valid_reg   <= {rd_valid_reg[0], scan_req};
            rd_blank_reg   <= {rd_blank_reg[0], !scan_in_range};
            scan_valid_reg <= rd_valid_reg[1];
        end
    end

    // Colour channels: index 0 = B, 1 = G, 2 = R, matching the {R,G,B} word layout.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [7:0] chan_reg;
            always_ff @(posedge CLOCK_400) begin
                if (reset)
                    chan_reg <= '0;
                else if (rd_valid_reg[1])
                    chan_reg <= rd_blank_reg[1] ? 8'h00 : mem_q[8*gi +: 8];
            end
        end
    endgenerate

    assign oR           = g_chan[2].chan_reg;
    assign oG           = g_chan[1].chan_reg;
    assign oB           = g_chan[0].chan_reg;
    assign scan_valid   = scan_valid_reg;
    assign draw_ack     = draw_ack_reg;
    assign front_bank   = front_bank_reg;
    assign mem_address  = mem_address_reg;
    assign mem_data     = mem_data_reg;
    assign mem_wren     = mem_wren_reg;

endmodule
